// File: rtl/day2_pkg.sv
// Shared constants and types for the day-2 ASCII range parser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package day2_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        START_NUM,
        END_NUM,
        FLUSH,
        DONE,
        ERROR
    } parser_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/day2_dec_accum.sv
// W-bit decimal accumulator: acc <= acc*10 + digit, with overflow detection.
// Latency: result registered one cycle after digit_vld; acc_nxt/ovf are combinational previews.
// Backpressure: none; the parent only pulses digit_vld on accepted digit bytes.
//
// Ports: clock, reset_n (async active-low); clear zeroes acc and the seen flag;
// digit_vld/digit shift in one decimal digit; acc is the running value, acc_nxt
// is the value acc would take on this digit, seen marks at least one digit since
// the last clear, ovf flags that acc_nxt does not fit in W bits.
module day2_dec_accum #(
    parameter int W = 48
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         digit_vld,
    input  logic [3:0]   digit,
    output logic [W-1:0] acc,
    output logic [W-1:0] acc_nxt,
    output logic         seen,
    output logic         ovf
);

    logic [W+3:0] acc_wide;
    logic [W+3:0] prod;

    // acc*10 as (acc<<3)+(acc<<1); four guard bits hold any overflow, even
    // after adding the incoming digit.
    assign acc_wide = {4'b0000, acc};
    assign prod     = (acc_wide << 3) + (acc_wide << 1) + {{W{1'b0}}, digit};
    assign acc_nxt  = prod[W-1:0];
    assign ovf      = |prod[W+3:W];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= '0;
            seen <= 1'b0;
        end else if (clear) begin
            acc  <= '0;
            seen <= 1'b0;
        end else if (digit_vld) begin
            acc  <= acc_nxt;
            seen <= 1'b1;
        end
    end

endmodule

// File: rtl/day2_range_parser.sv
// Streaming ASCII parser turning "a-b,c-d\n" text into start_id/end_id slot arrays for day2_puzzle.
// Latency: one byte per cycle; a range is written on the edge accepting its terminator, DONE two edges after in_last.
// Backpressure: in_ready depends on state only (high while parsing or draining after an error, low in IDLE/FLUSH/DONE).
//
// Ports: clock, reset_n (async active-low); in_valid/in_ready/in_data/in_last byte
// stream; start_id/end_id slot arrays and range_count; load (parsing), en (parse
// succeeded), parse_error (sticky until reset).
// Optional: define DAY2_PARSER_ORDER_CHECK_EN to reject ranges with start > end.
module day2_range_parser
    import day2_pkg::*;
#(
    parameter int W         = 48,
    parameter int NUM_UNITS = 38,
    parameter int CW        = $clog2(NUM_UNITS + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic [W-1:0]  start_id [0:NUM_UNITS-1],
    output logic [W-1:0]  end_id   [0:NUM_UNITS-1],
    output logic [CW-1:0] range_count,
    output logic          load,
    output logic          en,
    output logic          parse_error
);

    parser_state_t state, state_nxt;

    logic         fire;
    logic         is_dig;
    logic         is_sep;
    logic         is_term;
    logic         is_blank;
    logic         acc_clr;
    logic         acc_dig;
    logic         hold_we;
    logic         commit_req;
    logic         commit;
    logic         order_bad;
    logic [W-1:0] commit_end;
    logic [W-1:0] start_hold;
    logic [W-1:0] acc;
    logic [W-1:0] acc_nxt;
    logic         seen;
    logic         ovf;

    day2_dec_accum #(.W(W)) u_accum (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (acc_clr),
        .digit_vld (acc_dig),
        .digit     (in_data[3:0]),   // low nibble of '0'..'9' is the digit value
        .acc       (acc),
        .acc_nxt   (acc_nxt),
        .seen      (seen),
        .ovf       (ovf)
    );

    assign in_ready    = (state == START_NUM) || (state == END_NUM) || (state == ERROR);
    assign load        = (state == START_NUM) || (state == END_NUM);
    assign en          = (state == DONE);
    assign parse_error = (state == ERROR);
    assign fire        = in_valid && in_ready;

    assign is_dig   = is_digit(in_data);
    assign is_sep   = (in_data == ASCII_DASH)  || (in_data == ASCII_COLON);
    assign is_term  = (in_data == ASCII_COMMA) || (in_data == ASCII_LF);
    assign is_blank = (in_data == ASCII_SPACE) || (in_data == ASCII_CR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        acc_clr    = 1'b0;
        acc_dig    = 1'b0;
        hold_we    = 1'b0;
        commit_req = 1'b0;
        commit     = 1'b0;
        commit_end = acc;
        order_bad  = 1'b0;
        case (state)
            IDLE: state_nxt = START_NUM;

            START_NUM: begin
                if (fire) begin
                    if (is_dig) begin
                        // A number still open in the start field at end of file is an error.
                        if (ovf || in_last) state_nxt = ERROR;
                        else                acc_dig   = 1'b1;
                    end else if (is_sep && seen && !in_last) begin
                        hold_we   = 1'b1;
                        acc_clr   = 1'b1;
                        state_nxt = END_NUM;
                    end else if (is_blank || (is_term && !seen)) begin
                        if (in_last) state_nxt = seen ? ERROR : FLUSH;
                    end else begin
                        state_nxt = ERROR;
                    end
                end
            end

            END_NUM: begin
                if (fire) begin
                    if (is_dig && !ovf) begin
                        // The final digit of the file closes the range itself.
                        if (in_last) begin
                            commit_req = 1'b1;
                            commit_end = acc_nxt;
                        end else begin
                            acc_dig = 1'b1;
                        end
                    end else if (is_term && seen) begin
                        commit_req = 1'b1;
                    end else begin
                        state_nxt = ERROR;
                    end
`ifdef DAY2_PARSER_ORDER_CHECK_EN
                    order_bad = (start_hold > commit_end);
`endif
                    if (commit_req) begin
                        if ((range_count == CW'(NUM_UNITS)) || order_bad) begin
                            state_nxt = ERROR;
                        end else begin
                            commit    = 1'b1;
                            acc_clr   = 1'b1;
                            state_nxt = in_last ? FLUSH : START_NUM;
                        end
                    end
                end
            end

            FLUSH:   state_nxt = (range_count != '0) ? DONE : ERROR;
            DONE:    state_nxt = DONE;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                start_id[i] <= '0;
                end_id[i]   <= '0;
            end
            range_count <= '0;
            start_hold  <= '0;
        end else begin
            if (hold_we) start_hold <= acc;
            if (commit) begin
                for (int i = 0; i < NUM_UNITS; i++) begin
                    if (range_count == CW'(i)) begin
                        start_id[i] <= start_hold;
                        end_id[i]   <= commit_end;
                    end
                end
                range_count <= range_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_day2_range_parser.sv
module tb_day2_range_parser;

    localparam int W  = 48;
    localparam int NU = 38;
    localparam int CW = $clog2(NU + 1);
    localparam longint MAXV = 64'h0000_FFFF_FFFF_FFFF;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic          in_last = 1'b0;
    logic [W-1:0]  start_id [0:NU-1];
    logic [W-1:0]  end_id   [0:NU-1];
    logic [CW-1:0] range_count;
    logic          load;
    logic          en;
    logic          parse_error;

    int vectors = 0;
    int errors  = 0;

    longint exp_start [0:NU-1];
    longint exp_end   [0:NU-1];
    int     exp_cnt;
    bit     exp_err;

    always #5 clock = ~clock;

    day2_range_parser #(.W(W), .NUM_UNITS(NU), .CW(CW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .start_id    (start_id),
        .end_id      (end_id),
        .range_count (range_count),
        .load        (load),
        .en          (en),
        .parse_error (parse_error)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk the text as "start sep end term" records using 64-bit
    // integers; any deviation from that shape, a value above 2^48-1, or too many
    // records marks the file bad. Records accepted before the fault are kept.
    function automatic void model(input byte q[$]);
        bit     in_end = 0;
        bit     have   = 0;
        longint v      = 0;
        longint lo     = 0;
        exp_cnt = 0;
        exp_err = 0;
        for (int i = 0; i < NU; i++) begin
            exp_start[i] = 0;
            exp_end[i]   = 0;
        end
        for (int i = 0; i < q.size(); i++) begin
            byte c    = q[i];
            bit  last = (i == q.size() - 1);
            bit  close = 0;
            if (c >= "0" && c <= "9") begin
                v    = v * 10 + longint'(int'(c) - 48);
                have = 1;
                if (v > MAXV) exp_err = 1;
                else if (last) begin
                    if (in_end) close = 1;
                    else        exp_err = 1;
                end
            end else if (!in_end) begin
                if (c == "-" || c == ":") begin
                    if (!have || last) exp_err = 1;
                    else begin
                        lo = v; v = 0; have = 0; in_end = 1;
                    end
                end else if (c == " " || c == 8'h0D) begin
                    if (last && have) exp_err = 1;
                end else if (!((c == "," || c == 8'h0A) && !have)) begin
                    exp_err = 1;
                end
            end else begin
                if ((c == "," || c == 8'h0A) && have) close = 1;
                else exp_err = 1;
            end
            if (close) begin
                if (exp_cnt == NU) exp_err = 1;
`ifdef DAY2_PARSER_ORDER_CHECK_EN
                else if (lo > v) exp_err = 1;
`endif
                else begin
                    exp_start[exp_cnt] = lo;
                    exp_end[exp_cnt]   = v;
                    exp_cnt++;
                    v = 0; have = 0; in_end = 0;
                end
            end
            if (exp_err) break;
        end
        if (!exp_err && exp_cnt == 0) exp_err = 1;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input byte b, input bit last, input bit gappy);
        int waited = 0;
        if (gappy) begin
            while ($urandom_range(1) == 1) begin
                in_valid = 1'b0;
                @(negedge clock);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!in_ready) begin
            @(negedge clock);
            waited++;
            if (waited > 50) begin
                check_eq("ready_timeout", 64'd1, 64'd0);
                in_valid = 1'b0;
                return;
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic stream(input byte q[$], input bit gappy, input bit mark_last);
        for (int i = 0; i < q.size(); i++)
            send_byte(q[i], mark_last && (i == q.size() - 1), gappy);
    endtask

    function automatic void to_bytes(input string s, output byte q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endfunction

    task automatic compare_all(input string name, input byte q[$]);
        repeat (3) @(negedge clock);
        model(q);
        check_eq({name, " parse_error"}, 64'(parse_error), 64'(exp_err));
        check_eq({name, " en"},          64'(en),          64'(!exp_err));
        check_eq({name, " load"},        64'(load),        64'd0);
        check_eq({name, " in_ready"},    64'(in_ready),    64'(exp_err));
        check_eq({name, " range_count"}, 64'(range_count), 64'(exp_cnt));
        for (int i = 0; i < NU; i++) begin
            check_eq($sformatf("%s start_id[%0d]", name, i), 64'(start_id[i]), exp_start[i]);
            check_eq($sformatf("%s end_id[%0d]", name, i),   64'(end_id[i]),   exp_end[i]);
        end
    endtask

    task automatic run_case(input string name, input string s, input bit gappy);
        byte q[$];
        to_bytes(s, q);
        do_reset();
        stream(q, gappy, 1'b1);
        compare_all(name, q);
    endtask

    function automatic longint rand_num();
        case ($urandom_range(7))
            0:       return MAXV - 1 + longint'($urandom_range(0, 2));
            1:       return longint'($urandom_range(0, 9));
            2:       return {16'd0, 16'($urandom), 32'($urandom)};
            default: return longint'($urandom_range(0, 1000000));
        endcase
    endfunction

    function automatic string gen_case();
        string s = "";
        string sep;
        int    n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(3) == 0) s = {s, " "};
            if ($urandom_range(1) == 1) sep = "-"; else sep = ":";
            s = {s, $sformatf("%0d", rand_num()), sep, $sformatf("%0d", rand_num())};
            if ($urandom_range(15) == 0) s = {s, "x"};
            if (k < n - 1) begin
                if ($urandom_range(1) == 1) s = {s, ","}; else s = {s, "\n"};
            end
        end
        if ($urandom_range(1) == 1) s = {s, ","};
        return s;
    endfunction

    initial begin
        string big;
        byte   q[$];

        // Reset values while reset_n is held low.
        repeat (2) @(negedge clock);
        check_eq("rst range_count", 64'(range_count), 64'd0);
        check_eq("rst load",        64'(load),        64'd0);
        check_eq("rst en",          64'(en),          64'd0);
        check_eq("rst parse_error", 64'(parse_error), 64'd0);
        check_eq("rst in_ready",    64'(in_ready),    64'd0);
        check_eq("rst start_id[0]", 64'(start_id[0]), 64'd0);
        check_eq("rst end_id[37]",  64'(end_id[NU-1]), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("idle->start load",     64'(load),     64'd1);
        check_eq("idle->start in_ready", 64'(in_ready), 64'd1);

        run_case("basic",   "11-22,95-115\n", 1'b0);
        check_eq("basic end_id[1]", 64'(end_id[1]), 64'd115);
        run_case("colon",   "527473787:527596071", 1'b0);
        check_eq("colon start_id[0]", 64'(start_id[0]), 64'd527473787);
        run_case("gappy",   "1-2,3-4,", 1'b1);
        check_eq("gappy range_count", 64'(range_count), 64'd2);
        run_case("ovf",     "281474976710656-5", 1'b0);
        run_case("maxw",    "281474976710655-0\n", 1'b0);
        run_case("junk",    "12x-3", 1'b0);
        run_case("blank",   " 1\r-2\n\n", 1'b0);
        run_case("empty",   ",\n", 1'b0);
        run_case("zero",    "0-0", 1'b0);
        run_case("order",   "9-7", 1'b0);

        big = "";
        for (int i = 0; i < 39; i++) big = {big, "1-1,"};
        run_case("slots39", big, 1'b1);
        check_eq("slots39 range_count", 64'(range_count), 64'd38);
        check_eq("slots39 parse_error", 64'(parse_error), 64'd1);

        // Reset in the middle of a parse must clear committed slots at once.
        do_reset();
        to_bytes("5-6,11-2", q);
        stream(q, 1'b0, 1'b0);
        check_eq("midrst pre start_id[0]", 64'(start_id[0]), 64'd5);
        reset_n = 1'b0;
        #1;
        check_eq("midrst start_id[0]", 64'(start_id[0]), 64'd0);
        check_eq("midrst range_count", 64'(range_count), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        to_bytes("7-9", q);
        stream(q, 1'b0, 1'b1);
        compare_all("after_rst", q);

        for (int t = 0; t < 25; t++)
            run_case($sformatf("rand%0d", t), gen_case(), t[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/day2_range_parser.md
Name: day2_range_parser

Overview:
- Streaming ASCII front end for the day-2 range-sum engine (`day2_puzzle`).
- Consumes the puzzle input byte by byte: decimal ranges such as `11-22,95-115`.
- Fills the parallel `start_id`/`end_id` register arrays that `day2_puzzle` loads.
- Drives that block's `load` and `en` controls, so the file parse moves from the bench into RTL and the solver can be fed from a UART/AXI-Stream byte source.

Parameters:
- W, 48, width of each range bound; matches `day2_puzzle` W.
- NUM_UNITS, 38, number of range slots; matches `day2_puzzle` NUM_UNITS.
- CW, $clog2(NUM_UNITS+1), width of `range_count`.

Ports:
- clock  in  1  single system clock, all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  parser accepts a byte; a byte transfers when in_valid && in_ready.
- in_data  in  8  ASCII byte.
- in_last  in  1  marks the final byte of the input file.
- start_id  out  W x [0:NUM_UNITS-1]  parsed range starts; unused slots are 0.
- end_id  out  W x [0:NUM_UNITS-1]  parsed range ends; unused slots are 0.
- range_count  out  CW  number of ranges committed.
- load  out  1  high while parsing; connects to `day2_puzzle` load.
- en  out  1  high after a successful parse; connects to `day2_puzzle` en.
- parse_error  out  1  sticky error flag.

Behaviour:
- Reset (async, reset_n=0), all outputs:
  - start_id, end_id, range_count = 0.
  - load = 0, en = 0, parse_error = 0.
  - in_ready = 0.
  - State = IDLE.
- States:
  - IDLE → START_NUM on the first cycle after reset release; load=1 and in_ready=1 from that cycle.
  - START_NUM:
    - Digit: acc <= acc*10 + (byte-'0').
    - '-' or ':' with at least one digit seen: latch acc into the start holding register, clear acc, go to END_NUM.
    - Space and CR: ignored.
    - ',' or LF with no digits seen: ignored (empty field; handles a trailing comma or blank line).
    - Any other byte, or a separator with no digits: go to ERROR.
  - END_NUM:
    - Digit: accumulate.
    - ',', LF, or in_last with at least one digit: commit the range into slot range_count, increment range_count, clear acc, return to START_NUM.
    - Any other byte, or a terminator with no digits: go to ERROR.
  - FLUSH: entered when in_last is accepted.
    - The final byte is processed first; a digit on the last byte still commits.
    - Pending END_NUM digits commit as above; a pending START_NUM with digits goes to ERROR.
    - FLUSH lasts one cycle: in_ready=0, load=0.
    - Then DONE if range_count>0, else ERROR.
  - DONE: en=1 and held; in_ready=0; arrays frozen until reset.
  - ERROR: parse_error=1; load=0, en=0; in_ready=1 and all bytes are drained and discarded until reset.
- Arithmetic:
  - acc is W bits; acc*10 is computed as (acc<<3)+(acc<<1) in W+4 bits.
  - If the result has any nonzero bit above W-1: overflow → ERROR.
- Commit timing: the slot is written on the same edge that accepts the terminator byte; range_count is visible the next cycle.
- Slot overflow: a commit when range_count==NUM_UNITS → ERROR; existing slots are untouched.
- Throughput: one byte per cycle; in_ready is combinational from state only and never depends on in_valid.
- Reset mid-parse: all slots clear immediately; the parse restarts at IDLE.

Optional Feature:
- DAY2_PARSER_ORDER_CHECK_EN:
  - Defined: a commit with start > end → ERROR.
  - Not defined: the range is committed unchecked, and ordering is the solver's responsibility.

Decomposition:
- day2_pkg holds:
  - ASCII constants: ASCII_0, ASCII_9, ASCII_DASH, ASCII_COLON, ASCII_COMMA, ASCII_LF, ASCII_CR, ASCII_SPACE.
  - parser_state_t enum: IDLE, START_NUM, END_NUM, FLUSH, DONE, ERROR.
- One sub-module, day2_dec_accum:
  - W-bit decimal accumulator with clear, digit-in, and overflow-out.
  - Purely sequential register plus the shift-add.

Test Plan:
- `11-22,95-115\n` with in_last on LF → range_count=2, start_id[0]=11, end_id[0]=22, start_id[1]=95, end_id[1]=115, slots 2..37 = 0, en=1, parse_error=0.
- `527473787:527596071` with in_last on the final '1' → range_count=1, start_id[0]=527473787, end_id[0]=527596071, en=1.
- in_valid toggled randomly (50%) on `1-2,3-4,` → same result as back-to-back streaming: range_count=2, trailing comma ignored.
- 39 ranges `1-1,` x39 → parse_error=1 at the 39th commit, range_count=38, en=0.
- `281474976710656-5` (2^48, W=48) → parse_error=1 on the overflowing digit; `12x-3` → parse_error=1 at 'x'.
- reset_n pulsed low after `11-2`, then `7-9` sent with in_last → start_id[0]=7, end_id[0]=9, range_count=1. With DAY2_PARSER_ORDER_CHECK_EN defined, `9-7` → parse_error=1.
